// File: rtl/btn_cond_pkg.sv
// btn_cond_pkg: shared types and sizing helpers for the button input conditioner.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package btn_cond_pkg;

  // Per-channel auto-repeat state.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

  // Counter width for a counter that must reach value-1.
  // One spare bit keeps a zero/one-valued parameter legal.
  function automatic int cnt_width(input int value);
    return $clog2(value) + 1;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// btn_channel: one button lane. It synchronises the pin, debounces it, detects edges
// and produces auto-repeat move strobes.
// Latency: raw edge to btn_level/btn_press is DEBOUNCE_CYCLES+2 cycles.
// Backpressure: none. All outputs are registered single-cycle pulses or levels.
// Optional build macro BTN_PRESS_COUNT_EN adds a saturating 8-bit press counter.
// Ports:
//   clock, reset     : system clock and synchronous active-high reset
//   btn_raw          : raw asynchronous pin
//   enable           : 1 allows move strobes; 0 holds the repeat FSM in IDLE
//   btn_level        : debounced logical state (1 = pressed)
//   btn_press/release: 1-cycle debounced edge pulses
//   btn_move         : 1-cycle move strobe, on the press and on each auto-repeat
//   press_count      : saturating press counter (0 when the macro is absent)
module btn_channel
  import btn_cond_pkg::*;
#(
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_RATE     = 2500000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_raw,
  input  logic       enable,
  output logic       btn_level,
  output logic       btn_press,
  output logic       btn_release,
  output logic       btn_move,
  output logic [7:0] press_count
);

  localparam int DB_W = cnt_width(DEBOUNCE_CYCLES);
  localparam int RC_W = max_int(cnt_width(REPEAT_DELAY), cnt_width(REPEAT_RATE));
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RC_W-1:0] RD_LAST = RC_W'(REPEAT_DELAY - 1);
  localparam logic [RC_W-1:0] RR_LAST = RC_W'(REPEAT_RATE - 1);

  logic             pin_log;
  logic             sync1_q, sync1_d;
  logic             sync_q, sync_d;
  logic             level_q, level_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;
  logic             press_ev, rel_ev;
  rpt_state_e       state_q, state_d;
  logic [RC_W-1:0]  rc_q, rc_d;
  logic             move_q, move_d;

  // The polarity is fixed before the synchroniser, so reset value 0 always means released.
  assign pin_log = (ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;

  // Synchroniser and debounce.
  always_comb begin
    sync1_d  = pin_log;
    sync_d   = sync1_q;
    level_d  = level_q;
    db_cnt_d = '0;
    press_ev = 1'b0;
    rel_ev   = 1'b0;
    if (sync_q != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_d  = sync_q;
        press_ev = sync_q;
        rel_ev   = ~sync_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
    press_d = press_ev;
    rel_d   = rel_ev;
  end

  // Repeat FSM. Next state uses this cycle's debounce events, so the press move
  // registers on the same edge as btn_press.
  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    move_d  = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      rc_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          rc_d = '0;
          if (press_ev) begin
            state_d = DELAY;
            move_d  = 1'b1;
          end else if (level_q && !rel_ev) begin
            // Button already held when enable returns: restart the delay, no move.
            state_d = DELAY;
          end
        end
        DELAY: begin
          if (rel_ev) begin
            state_d = IDLE;
            rc_d    = '0;
          end else if (REPEAT_DELAY == 0) begin
            // Repeat disabled: park here until release.
            rc_d = '0;
          end else if (rc_q == RD_LAST) begin
            state_d = REPEAT;
            rc_d    = '0;
            move_d  = 1'b1;
          end else begin
            rc_d = rc_q + 1'b1;
          end
        end
        REPEAT: begin
          if (rel_ev) begin
            state_d = IDLE;
            rc_d    = '0;
          end else if (rc_q == RR_LAST) begin
            rc_d   = '0;
            move_d = 1'b1;
          end else begin
            rc_d = rc_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          rc_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync_q   <= 1'b0;
      level_q  <= 1'b0;
      db_cnt_q <= '0;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
      state_q  <= IDLE;
      rc_q     <= '0;
      move_q   <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync_q   <= sync_d;
      level_q  <= level_d;
      db_cnt_q <= db_cnt_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
      state_q  <= state_d;
      rc_q     <= rc_d;
      move_q   <= move_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = rel_q;
  assign btn_move    = move_q;

`ifdef BTN_PRESS_COUNT_EN
  logic [7:0] pcnt_q, pcnt_d;

  // Saturates at 255 so a debug display never wraps back to a small value.
  always_comb begin
    pcnt_d = pcnt_q;
    if (press_ev && (pcnt_q != 8'hFF)) begin
      pcnt_d = pcnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pcnt_q <= 8'd0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

  assign press_count = pcnt_q;
`else
  assign press_count = 8'd0;
`endif

endmodule

// File: rtl/btn_input_conditioner.sv
// btn_input_conditioner: N-channel game-button conditioner with debounce, edge pulses
// and auto-repeat move strobes.
// Latency: raw edge to btn_level/btn_press/first btn_move is DEBOUNCE_CYCLES+2 cycles.
// Backpressure: none. The outputs are free-running strobes for the game control block.
// Optional build macro BTN_PRESS_COUNT_EN adds per-channel saturating press counters.
// Ports:
//   clock, reset : system clock and synchronous active-high reset
//   btn_raw      : N_CH raw asynchronous pins
//   enable       : global move enable
//   btn_level, btn_press, btn_release, btn_move : N_CH-wide per-channel outputs
//   press_count  : 8 bits per channel, channel i at [8*i+7:8*i]
module btn_input_conditioner
  import btn_cond_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_RATE     = 2500000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_CH-1:0]   btn_raw,
  input  logic              enable,
  output logic [N_CH-1:0]   btn_level,
  output logic [N_CH-1:0]   btn_press,
  output logic [N_CH-1:0]   btn_release,
  output logic [N_CH-1:0]   btn_move,
  output logic [8*N_CH-1:0] press_count
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    btn_channel #(
      .ACTIVE_LOW      (ACTIVE_LOW),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_RATE     (REPEAT_RATE)
    ) u_ch (
      .clock       (clock),
      .reset       (reset),
      .btn_raw     (btn_raw[i]),
      .enable      (enable),
      .btn_level   (btn_level[i]),
      .btn_press   (btn_press[i]),
      .btn_release (btn_release[i]),
      .btn_move    (btn_move[i]),
      .press_count (press_count[8*i +: 8])
    );
  end

endmodule

// File: tb/tb_btn_input_conditioner.sv
// tb_btn_input_conditioner: scoreboard bench for the button conditioner.
// Stimulus tasks push expected press/release/move events with their cycle numbers.
// A negedge monitor pops them and compares all outputs every cycle.
module tb_btn_input_conditioner;

  localparam int N  = 4;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RR = 3;
  localparam int LAT = DB + 2;

  logic           clock = 1'b0;
  logic           reset;
  logic [N-1:0]   btn_raw;
  logic           enable;
  logic [N-1:0]   btn_level, btn_press, btn_release, btn_move;
  logic [8*N-1:0] press_count;

  btn_input_conditioner #(
    .N_CH(N), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .btn_raw     (btn_raw),
    .enable      (enable),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_move    (btn_move),
    .press_count (press_count)
  );

  always #5 clock = ~clock;

  // cyc = number of the most recent rising edge.
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int ch;
    int kind;   // 0 press, 1 release, 2 move
  } ev_t;

  ev_t      exp_q[$];
  logic [N-1:0] exp_level = '0;
  int       rst_cyc = 1;
  int       n_vec = 0;
  int       n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic void push_ev(input int c, input int ch, input int kind);
    ev_t e;
    e.cyc = c; e.ch = ch; e.kind = kind;
    exp_q.push_back(e);
  endfunction

  // Expected events for one held press: press at p, optional move at p, repeat
  // moves from rep0 every RR cycles strictly before r, optional release at r.
  function automatic void push_ch(input int ch, input int p, input bit pmove,
                                  input int rep0, input int r, input bit do_rel);
    push_ev(p, ch, 0);
    if (pmove) push_ev(p, ch, 2);
    for (int m = rep0; m < r; m += RR) push_ev(m, ch, 2);
    if (do_rel) push_ev(r, ch, 1);
  endfunction

  always @(negedge clock) begin
    logic [N-1:0] ep, er, em;
    ep = '0; er = '0; em = '0;
    if (cyc == rst_cyc) exp_level = '0;
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc <= cyc) begin
        case (exp_q[i].kind)
          0:       ep[exp_q[i].ch] = 1'b1;
          1:       er[exp_q[i].ch] = 1'b1;
          default: em[exp_q[i].ch] = 1'b1;
        endcase
        exp_q.delete(i);
      end
    end
    exp_level = (exp_level | ep) & ~er;
    check_val("outs{lvl,prs,rel,mov}",
              {16'h0, btn_level, btn_press, btn_release, btn_move},
              {16'h0, exp_level, ep, er, em});
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // One-cycle reset pulse, sampled on the next edge. Events not yet due are cancelled.
  task automatic apply_reset();
    reset   = 1'b1;
    rst_cyc = cyc + 1;
    for (int i = exp_q.size() - 1; i >= 0; i--)
      if (exp_q[i].cyc > cyc) exp_q.delete(i);
    tick(1);
    reset = 1'b0;
  endtask

  function automatic logic [31:0] exp_count(input int n2);
`ifdef BTN_PRESS_COUNT_EN
    return 32'((n2 > 255) ? 255 : n2) << 16;
`else
    return 32'(n2 & 0);
`endif
  endfunction

  initial begin
    int t;
    int r0;
    reset   = 1'b1;
    enable  = 1'b1;
    btn_raw = '1;
    tick(3);
    reset = 1'b0;
    tick(5);

    // Glitch: 3 cycles low is one short of the debounce window.
    btn_raw[0] = 1'b0;
    tick(3);
    btn_raw[0] = 1'b1;
    tick(15);

    // Hold and release on channel 1.
    t = cyc;
    push_ch(1, t + LAT, 1'b1, t + LAT + RD, t + 30 + LAT, 1'b1);
    btn_raw[1] = 1'b0;
    tick(30);
    btn_raw[1] = 1'b1;
    tick(15);

    // Enable gating on channel 2: press while disabled, enable sampled at t+20.
    t = cyc;
    enable = 1'b0;
    btn_raw[2] = 1'b0;
    push_ch(2, t + LAT, 1'b0, t + 20 + RD, t + 40 + LAT, 1'b1);
    tick(19);
    enable = 1'b1;
    tick(21);
    btn_raw[2] = 1'b1;
    tick(15);

    // Simultaneous channels 0 and 3.
    t = cyc;
    push_ch(0, t + LAT, 1'b1, t + LAT + RD, t + 20 + LAT, 1'b1);
    push_ch(3, t + LAT, 1'b1, t + LAT + RD, t + 20 + LAT, 1'b1);
    btn_raw[0] = 1'b0;
    btn_raw[3] = 1'b0;
    tick(20);
    btn_raw[0] = 1'b1;
    btn_raw[3] = 1'b1;
    tick(15);

    // Reset mid-repeat on channel 1, with the pin still held.
    t = cyc;
    push_ch(1, t + LAT, 1'b1, t + LAT + RD, t + 20, 1'b0);
    btn_raw[1] = 1'b0;
    tick(19);
    apply_reset();
    r0 = cyc;
    push_ch(1, r0 + LAT, 1'b1, r0 + LAT + RD, r0 + 20 + LAT, 1'b1);
    tick(20);
    btn_raw[1] = 1'b1;
    tick(15);

    // Press counter: cleared by reset, 300 clean presses on channel 2.
    apply_reset();
    tick(3);
    check_val("cnt_clr", press_count, 32'h0);
    for (int i = 0; i < 300; i++) begin
      t = cyc;
      push_ch(2, t + LAT, 1'b1, t + LAT + RD, t + 6 + LAT, 1'b1);
      btn_raw[2] = 1'b0;
      tick(6);
      btn_raw[2] = 1'b1;
      tick(9);
      if (i == 9) check_val("cnt_10", press_count, exp_count(10));
    end
    check_val("cnt_sat", press_count, exp_count(300));

    tick(5);
    check_val("q_empty", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/btn_input_conditioner.md
Name: btn_input_conditioner

Overview:
- N-channel conditioner for game buttons (up/left/down/right and any added keys) feeding the tetris controller.
- Per channel: synchronises the raw pin, debounces it, and detects press and release edges.
- Generates delayed auto-repeat "move" pulses while a button is held, so the game logic sees clean single-cycle move strobes instead of raw levels.
- Sits between the board pins and the game control block, in the clock domain of that block.

Parameters:
- N_CH, 4, number of button channels.
- ACTIVE_LOW, 1, 1 = pin reads 0 when pressed; inverted to logical pressed = 1.
- DEBOUNCE_CYCLES, 250000, consecutive stable synchronised cycles required to accept a change (>=1).
- REPEAT_DELAY, 12500000, cycles from press to first auto-repeat move (0 = repeat disabled).
- REPEAT_RATE, 2500000, cycles between subsequent auto-repeat moves (>=1).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- btn_raw  in  N_CH  raw asynchronous button pins
- enable  in  1  1 = move pulses allowed; 0 = moves suppressed, repeat held idle
- btn_level  out  N_CH  debounced logical state (1 = pressed)
- btn_press  out  N_CH  1-cycle pulse on debounced press
- btn_release  out  N_CH  1-cycle pulse on debounced release
- btn_move  out  N_CH  1-cycle move strobe: on the press, then on each auto-repeat
- press_count  out  8*N_CH  per-channel press counters; see Optional Feature

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Reset:
  - Sync flops load the logical-released value (0).
  - btn_level, btn_press, btn_release, btn_move and press_count all go to 0.
  - All counters clear and repeat FSMs go to IDLE.
  - Reset wins over all other events in the same cycle.
- Synchronisation: 2-flop synchroniser per channel, with the ACTIVE_LOW inversion applied before it. The output is sync.
- Debounce:
  - cnt clears whenever sync == btn_level; otherwise it increments.
  - When sync != btn_level and cnt == DEBOUNCE_CYCLES-1: btn_level <= sync and cnt <= 0.
  - btn_press (or btn_release) is registered and asserts on the same edge that btn_level changes.
  - Total latency from a raw edge to btn_level: DEBOUNCE_CYCLES+2 cycles.
  - A glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no output.
- Repeat FSM, per channel, states IDLE, DELAY, REPEAT:
  - IDLE -> DELAY on btn_press with enable=1. btn_move pulses in the same cycle as btn_press, and the repeat counter rc <= 0.
  - DELAY: rc increments. When rc == REPEAT_DELAY-1: btn_move pulses, rc <= 0, state -> REPEAT.
  - REPEAT: rc increments. When rc == REPEAT_RATE-1: btn_move pulses, rc <= 0.
  - DELAY/REPEAT -> IDLE on btn_release, with no move in that cycle.
  - REPEAT_DELAY == 0: the FSM never leaves DELAY; only the press move is produced.
- enable:
  - While enable=0, btn_move is forced to 0 and the FSM is forced to IDLE. Debounce, btn_level, btn_press and btn_release continue to operate.
  - enable 0->1 while btn_level=1: FSM enters DELAY with rc=0 and no immediate move.
- Channels are fully independent. Any combination of simultaneous pulses is legal.
- Counter widths are $clog2(param)+1 bits. No wrap is possible, because compares use ==param-1 and then clear.

Optional Feature:
- Macro BTN_PRESS_COUNT_EN.
- When defined: each channel keeps an 8-bit counter, incremented on btn_press and saturating at 255, cleared by reset. The counter is driven onto press_count[8*i+7:8*i] for seven-segment or LED debug.
- When undefined: press_count is tied to 0 and no counter flops are built.

Decomposition:
- Package btn_cond_pkg holds:
  - the repeat FSM state enum (IDLE=2'd0, DELAY=2'd1, REPEAT=2'd2);
  - a width helper function for the counter sizes.
- Sub-module btn_channel: sync, debounce, edge detect, repeat FSM and optional counter for one channel. The top generate-loops N_CH instances and packs the outputs.

Test Plan (N_CH=4, ACTIVE_LOW=1, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, enable=1, cycle 0 = raw edge):
- Glitch rejection:
  - Stimulus: btn_raw[0] low for 3 cycles, then high.
  - Response: btn_level[0] stays 0; no press, release or move pulse.
- Hold and release:
  - Stimulus: btn_raw[1] low at cycle 0, released (high) at cycle 30.
  - Response: btn_level[1] and btn_press[1] rise at cycle 6. btn_move[1] pulses at 6, 16, 19, 22, 25, 28, 31, 34. btn_release[1] pulses at 36. No move at 36 or after.
- Enable gating:
  - Stimulus: enable=0, btn_raw[2] held low; enable raised at cycle 20.
  - Response: btn_press[2] at 6 with no move. Moves at 30, 33, 36, and so on.
- Reset mid-repeat:
  - Stimulus: btn_raw[1] held, reset=1 for one cycle at cycle 20.
  - Response: all outputs 0 at cycle 21. With the pin still held, btn_press[1] and btn_move[1] pulse 6 cycles after reset deasserts.
- Simultaneous channels:
  - Stimulus: btn_raw[0] and btn_raw[3] fall in the same cycle.
  - Response: identical press and move pulses on bits 0 and 3 in the same cycles; bits 1 and 2 idle.
- Counter saturation (BTN_PRESS_COUNT_EN defined):
  - Stimulus: 300 clean presses on channel 2.
  - Response: press_count[23:16] == 255 and the other fields == 0.
  - Without the macro, press_count == 0.
